// File: rtl/alu_mdu_seq.sv
// Registered EX-stage ALU with iterative unsigned multiply/divide and a valid/ready
// handshake on both sides. Simple ops complete in one cycle; mul/div take WIDTH+1.
module alu_mdu_seq #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [3:0]       i_alu_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_alu_out,
  output logic             o_zero,
  output logic             o_illegal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_PASSB = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULHU = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd11;

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [3:0]       aluOp_q,   aluOp_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             zero_q,    zero_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             reqIterative;
  logic             reqDiv;
  logic             reqLegal;
  logic [WIDTH-1:0] acceptResult;
  logic             busyDiv;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divDiff;
  logic             divFits;
  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;
  logic [WIDTH-1:0] finalResult;

  assign o_ready   = (state_q == IDLE) | ((state_q == DONE) & i_ready);
  assign o_valid   = (state_q == DONE);
  assign o_alu_out = result_q;
  assign o_zero    = zero_q;
  assign o_illegal = illegal_q;

  assign accept = i_valid & o_ready;

  // Decode of the incoming request plus the result for every op that finishes at accept.
  always_comb begin
    reqIterative = 1'b0;
    reqDiv       = 1'b0;
    reqLegal     = 1'b1;
    acceptResult = '0;
    case (i_alu_op)
      OP_ADD:   acceptResult = i_op_a + i_op_b;
      OP_SUB:   acceptResult = i_op_a - i_op_b;
      OP_AND:   acceptResult = i_op_a & i_op_b;
      OP_OR:    acceptResult = i_op_a | i_op_b;
      OP_PASSB: acceptResult = i_op_b;
      OP_SLT:   acceptResult = {{(WIDTH-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      OP_SLTU:  acceptResult = {{(WIDTH-1){1'b0}}, (i_op_a < i_op_b)};
      OP_MUL, OP_MULHU: reqIterative = 1'b1;
      OP_DIVU: begin
        reqIterative = 1'b1;
        reqDiv       = 1'b1;
        acceptResult = '1;
      end
      OP_REMU: begin
        reqIterative = 1'b1;
        reqDiv       = 1'b1;
        acceptResult = i_op_a;
      end
      default:  reqLegal = 1'b0;
    endcase
  end

  // One shift-add multiply step: {hi,lo} holds the partial product with the multiplier in lo.
  assign mulSum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});

  // One restoring divide step: hi is the remainder, lo shifts the dividend out and quotient in.
  assign divShift = {hi_q, lo_q[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, operand_q};
  assign divFits  = ~divDiff[WIDTH];

  assign busyDiv = (aluOp_q == OP_DIVU) | (aluOp_q == OP_REMU);

  always_comb begin
    stepHi = mulSum[WIDTH:1];
    stepLo = {mulSum[0], lo_q[WIDTH-1:1]};
    if (busyDiv) begin
      stepHi = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      stepLo = {lo_q[WIDTH-2:0], divFits};
    end
  end

  always_comb begin
    finalResult = '0;
    case (aluOp_q)
      OP_MUL:   finalResult = stepLo;
      OP_MULHU: finalResult = stepHi;
      OP_DIVU:  finalResult = stepLo;
      OP_REMU:  finalResult = stepHi;
      default:  finalResult = '0;
    endcase
  end

  // Control FSM; DONE re-accepts directly so simple ops can stream at one per cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    aluOp_d   = aluOp_q;
    operand_d = operand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          aluOp_d   = i_alu_op;
          zero_d    = (i_op_a == i_op_b);
          illegal_d = ~reqLegal;
          if (reqIterative && !(reqDiv && (i_op_b == '0))) begin
            state_d   = BUSY;
            count_d   = CNT_W'(WIDTH);
            operand_d = reqDiv ? i_op_b : i_op_a;
            hi_d      = '0;
            lo_d      = reqDiv ? i_op_a : i_op_b;
          end else begin
            state_d  = DONE;
            result_d = acceptResult;
          end
        end else if (state_q == DONE && i_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        hi_d    = stepHi;
        lo_d    = stepLo;
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = finalResult;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      aluOp_q   <= '0;
      operand_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      aluOp_q   <= aluOp_d;
      operand_q <= operand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: a 32-bit instance for the main sequence and an
// 8-bit instance for the narrow divide case.
module tb_alu_mdu_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [3:0]  i_alu_op;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_alu_out;
  logic        o_zero;
  logic        o_illegal;

  logic        narrowValid;
  logic        narrowReadyOut;
  logic [7:0]  narrowOpA;
  logic [7:0]  narrowOpB;
  logic [3:0]  narrowAluOp;
  logic        narrowValidOut;
  logic        narrowReadyIn;
  logic [7:0]  narrowOut;
  logic        narrowZero;
  logic        narrowIllegal;

  int checks = 0;
  int passes = 0;

  always #5 i_clk = ~i_clk;

  alu_mdu_seq #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_alu_op(i_alu_op), .o_valid(o_valid),
    .i_ready(i_ready), .o_alu_out(o_alu_out), .o_zero(o_zero), .o_illegal(o_illegal)
  );

  alu_mdu_seq #(.WIDTH(8)) dutNarrow (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(narrowValid), .o_ready(narrowReadyOut),
    .i_op_a(narrowOpA), .i_op_b(narrowOpB), .i_alu_op(narrowAluOp), .o_valid(narrowValidOut),
    .i_ready(narrowReadyIn), .o_alu_out(narrowOut), .o_zero(narrowZero), .o_illegal(narrowIllegal)
  );

  // Single comparison point: counts every check and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Presents one request for exactly one edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    i_alu_op = op;
    i_op_a   = a;
    i_op_b   = b;
    i_valid  = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
  endtask

  // Counts cycles from accept until o_valid, and how often o_ready was seen high meanwhile.
  task automatic waitValid(input int limit, output int latency, output int readyHigh);
    latency   = 1;
    readyHigh = 0;
    while (!o_valid && latency < limit) begin
      if (o_ready) readyHigh++;
      @(posedge i_clk);
      #1;
      latency++;
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expOut, input int expLat);
    int lat;
    int rdy;
    applyStimulus(op, a, b);
    waitValid(80, lat, rdy);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_readyBusy"}, 32'(rdy), 32'd0);
    checkOutput({tag, "_out"}, o_alu_out, expOut);
  endtask

  initial begin
    int lat;
    i_rst         = 1'b1;
    i_valid       = 1'b0;
    i_ready       = 1'b1;
    i_op_a        = '0;
    i_op_b        = '0;
    i_alu_op      = '0;
    narrowValid   = 1'b0;
    narrowReadyIn = 1'b1;
    narrowOpA     = '0;
    narrowOpB     = '0;
    narrowAluOp   = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_valid",   32'(o_valid),   32'd0);
    checkOutput("reset_ready",   32'(o_ready),   32'd1);
    checkOutput("reset_out",     o_alu_out,      32'd0);
    checkOutput("reset_zero",    32'(o_zero),    32'd0);
    checkOutput("reset_illegal", 32'(o_illegal), 32'd0);
    i_rst = 1'b0;

    applyStimulus(4'd0, 32'hFFFF_FFFF, 32'd1);
    checkOutput("add_valid", 32'(o_valid), 32'd1);
    checkOutput("add_out",   o_alu_out,    32'd0);
    checkOutput("add_zero",  32'(o_zero),  32'd0);
    applyStimulus(4'd1, 32'd5, 32'd5);
    checkOutput("sub_valid", 32'(o_valid), 32'd1);
    checkOutput("sub_out",   o_alu_out,    32'd0);
    checkOutput("sub_zero",  32'(o_zero),  32'd1);
    applyStimulus(4'd5, 32'hFFFF_FFFF, 32'd1);
    checkOutput("slt_out",   o_alu_out,    32'd1);
    applyStimulus(4'd6, 32'hFFFF_FFFF, 32'd1);
    checkOutput("sltu_out",  o_alu_out,    32'd0);
    applyStimulus(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
    checkOutput("and_out",   o_alu_out,    32'h00F0_1200);
    applyStimulus(4'd3, 32'hF000_0001, 32'h0000_0100);
    checkOutput("or_out",    o_alu_out,    32'hF000_0101);
    applyStimulus(4'd4, 32'd1, 32'hCAFE_BABE);
    checkOutput("passb_out", o_alu_out,    32'hCAFE_BABE);
    applyStimulus(4'd13, 32'd7, 32'd9);
    checkOutput("illegal_out",  o_alu_out,    32'd0);
    checkOutput("illegal_flag", 32'(o_illegal), 32'd1);

    runOp("mul",   4'd8,  32'h0001_0000, 32'h0001_0000, 32'd0, 33);
    checkOutput("illegal_cleared", 32'(o_illegal), 32'd0);
    runOp("mulhu", 4'd9,  32'h0001_0000, 32'h0001_0000, 32'd1, 33);
    runOp("mul_b", 4'd8,  32'd12345, 32'd678, 32'd8369910, 33);
    runOp("divu",  4'd10, 32'd100, 32'd7, 32'd14, 33);
    runOp("remu",  4'd11, 32'd100, 32'd7, 32'd2, 33);
    runOp("divu0", 4'd10, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("remu0", 4'd11, 32'd9, 32'd0, 32'd9, 1);

    applyStimulus(4'd0, 32'd7, 32'd8);
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_valid  = (k % 2 == 0);
      i_alu_op = 4'd0;
      i_op_a   = 32'd100 + 32'(k);
      i_op_b   = 32'd1;
      @(posedge i_clk);
      #1;
      checkOutput("hold_valid", 32'(o_valid), 32'd1);
      checkOutput("hold_out",   o_alu_out,    32'd15);
      checkOutput("hold_ready", 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("release_valid", 32'(o_valid), 32'd0);

    applyStimulus(4'd10, 32'd100, 32'd7);
    repeat (9) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("abort_valid", 32'(o_valid), 32'd0);
    checkOutput("abort_ready", 32'(o_ready), 32'd1);
    checkOutput("abort_out",   o_alu_out,    32'd0);
    i_rst = 1'b0;
    runOp("add_after_abort", 4'd0, 32'd2, 32'd3, 32'd5, 1);

    narrowAluOp = 4'd10;
    narrowOpA   = 8'd200;
    narrowOpB   = 8'd3;
    narrowValid = 1'b1;
    @(posedge i_clk);
    #1;
    narrowValid = 1'b0;
    lat = 1;
    while (!narrowValidOut && lat < 40) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    checkOutput("div8_latency", 32'(lat), 32'd9);
    checkOutput("div8_out",     32'(narrowOut), 32'd66);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
